// File: rtl/upb_tcam_if.sv
// -----------------------------------------------------------------------------
// upb_tcam_if
// Bus bundle for the upb_tcam lookup engine.
//   Write channel : wr_valid / wr_ready handshake carrying wr_invalidate,
//                   wr_addr, wr_value, wr_mask.
//   Lookup channel: lookup_valid / lookup_key in, result_valid / result_hit /
//                   result_addr out (two-cycle latency).
//   Optional      : result_match (full match vector), present only when
//                   UPB_TCAM_MATCH_VEC_EN is defined.
// Modports: master = key generator / control plane, slave = TCAM.
// -----------------------------------------------------------------------------
interface upb_tcam_if #(
  parameter int KEY_WIDTH = 10,
  parameter int ENTRIES   = 16
);
  localparam int AW = $clog2(ENTRIES);

  logic                 wr_valid;
  logic                 wr_ready;
  logic                 wr_invalidate;
  logic [AW-1:0]        wr_addr;
  logic [KEY_WIDTH-1:0] wr_value;
  logic [KEY_WIDTH-1:0] wr_mask;

  logic                 lookup_valid;
  logic [KEY_WIDTH-1:0] lookup_key;

  logic                 result_valid;
  logic                 result_hit;
  logic [AW-1:0]        result_addr;
`ifdef UPB_TCAM_MATCH_VEC_EN
  logic [ENTRIES-1:0]   result_match;
`endif

  modport master (
`ifdef UPB_TCAM_MATCH_VEC_EN
    input  result_match,
`endif
    output wr_valid, wr_invalidate, wr_addr, wr_value, wr_mask,
    output lookup_valid, lookup_key,
    input  wr_ready, result_valid, result_hit, result_addr
  );

  modport slave (
`ifdef UPB_TCAM_MATCH_VEC_EN
    output result_match,
`endif
    input  wr_valid, wr_invalidate, wr_addr, wr_value, wr_mask,
    input  lookup_valid, lookup_key,
    output wr_ready, result_valid, result_hit, result_addr
  );
endinterface

// File: rtl/upb_tcam.sv
// -----------------------------------------------------------------------------
// upb_tcam
// Multi-entry SRL-style ternary CAM on the OpenFlow lookup path. Each entry
// holds TCAM_WIDTH shift registers of SRL_SIZE bits; chunk c of the key
// (CW = log2(SRL_SIZE) bits) addresses its SRL and the addressed bit says
// whether that chunk matches. A write controller serialises the value/mask
// LUT into the target entry's SRLs; lookups are pipelined (latency 2) with
// lowest-index priority.
//
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   bus       upb_tcam_if.slave: write handshake, lookup key, result
//
// Optional feature: define UPB_TCAM_MATCH_VEC_EN to add bus.result_match,
// the registered valid-masked match vector aligned with result_valid.
// -----------------------------------------------------------------------------
module upb_tcam #(
  parameter int SRL_SIZE   = 32,
  parameter int TCAM_WIDTH = 2,
  parameter int ENTRIES    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  upb_tcam_if.slave   bus
);
  localparam int CW        = $clog2(SRL_SIZE);
  localparam int KEY_WIDTH = CW * TCAM_WIDTH;
  localparam int AW        = $clog2(ENTRIES);
  localparam logic [AW:0] ENTRIES_W = (AW+1)'(ENTRIES);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic                 wr_ready, shift_en, set_valid;
  logic                 accept, addr_ok;

  logic [AW-1:0]        addr_q;
  logic [KEY_WIDTH-1:0] value_q, mask_q;
  logic [CW-1:0]        cnt_q;
  logic [ENTRIES-1:0]   valid_q;

  logic [SRL_SIZE-1:0]  srl_q [ENTRIES][TCAM_WIDTH];
  logic [TCAM_WIDTH-1:0] lut_bit;

  logic                 s1_valid_q;
  logic [ENTRIES-1:0]   match_comb, match_q;
  logic                 pe_hit;
  logic [AW-1:0]        pe_addr;

  logic                 result_valid_q, result_hit_q;
  logic [AW-1:0]        result_addr_q;

  assign accept  = bus.wr_valid && wr_ready;
  // Out-of-range addresses are accepted but never touch state.
  assign addr_ok = ({1'b0, bus.wr_addr} < ENTRIES_W);

  // ---------------------------------------------------------------------------
  // Write controller FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !bus.wr_invalidate && addr_ok) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready  = (state_q == IDLE);
    shift_en  = (state_q == SHIFT);
    set_valid = (state_q == DONE);
  end

  assign bus.wr_ready = wr_ready;

  // Request capture and bit counter. Only meaningful while writing, so no
  // reset is needed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= bus.wr_addr;
      value_q <= bus.wr_value;
      mask_q  <= bus.wr_mask;
      cnt_q   <= '1;
    end else if (shift_en) begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  // Valid bits: cleared at handshake (so a half-written LUT is never seen),
  // set once the last bit has been shifted in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else begin
      if (accept && addr_ok) valid_q[bus.wr_addr] <= 1'b0;
      if (set_valid)         valid_q[addr_q]      <= 1'b1;
    end
  end

  // LUT bit for position cnt_q of each chunk: 1 when that chunk value
  // matches value/mask on all cared bits.
  always_comb begin
    lut_bit = '0;
    for (int c = 0; c < TCAM_WIDTH; c++)
      lut_bit[c] = (((cnt_q ^ value_q[c*CW +: CW]) & mask_q[c*CW +: CW]) == '0);
  end

  // NOTE: the SRL array is deliberately not reset; cleared valid bits mask
  // stale contents, and leaving it resetless keeps it mappable to SRL primitives.
  // Shifting MSB first lands LUT bit j at SRL position j after SRL_SIZE shifts.
  always_ff @(posedge CLK) begin
    if (shift_en) begin
      for (int c = 0; c < TCAM_WIDTH; c++)
        srl_q[addr_q][c] <= {srl_q[addr_q][c][SRL_SIZE-2:0], lut_bit[c]};
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    match_comb = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      match_comb[e] = valid_q[e];
      for (int c = 0; c < TCAM_WIDTH; c++)
        match_comb[e] = match_comb[e] & srl_q[e][c][bus.lookup_key[c*CW +: CW]];
    end
  end

  // Stage 1: registered match vector.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      match_q    <= '0;
    end else begin
      s1_valid_q <= bus.lookup_valid;
      if (bus.lookup_valid) match_q <= match_comb;
    end
  end

  // Lowest index wins: scan downwards so the last assignment is the lowest.
  always_comb begin
    pe_hit  = 1'b0;
    pe_addr = '0;
    for (int e = ENTRIES-1; e >= 0; e--) begin
      if (match_q[e]) begin
        pe_hit  = 1'b1;
        pe_addr = AW'(e);
      end
    end
  end

  // Stage 2: result; hit/addr hold when no lookup is in this slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      result_addr_q  <= '0;
    end else begin
      result_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_hit_q  <= pe_hit;
        result_addr_q <= pe_addr;
      end
    end
  end

  assign bus.result_valid = result_valid_q;
  assign bus.result_hit   = result_hit_q;
  assign bus.result_addr  = result_addr_q;

`ifdef UPB_TCAM_MATCH_VEC_EN
  logic [ENTRIES-1:0] result_match_q;

  always_ff @(posedge CLK) begin
    if (RST)             result_match_q <= '0;
    else if (s1_valid_q) result_match_q <= match_q;
  end

  assign bus.result_match = result_match_q;
`endif

endmodule

// File: tb/tb_upb_tcam.sv
// -----------------------------------------------------------------------------
// tb_upb_tcam
// Self-checking bench for upb_tcam at default parameters (10-bit key,
// 16 entries). Lookup expectations are queued at issue time, either from
// constant vectors or from a behavioural ternary model, and compared when
// result_valid appears, including the two-cycle latency.
// -----------------------------------------------------------------------------
module tb_upb_tcam;
  localparam int KW = 10;
  localparam int NE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  upb_tcam_if #(.KEY_WIDTH(KW), .ENTRIES(NE)) bus ();

  upb_tcam #(.SRL_SIZE(32), .TCAM_WIDTH(2), .ENTRIES(NE)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic       hit;
    logic [3:0] addr;
    int         due;
  } exp_t;

  typedef struct {
    logic [KW-1:0] key;
    logic          hit;
    logic [3:0]    addr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  // Behavioural reference: plain ternary compare per entry.
  logic          ref_valid [NE];
  logic [KW-1:0] ref_value [NE];
  logic [KW-1:0] ref_mask  [NE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;
  endtask

  task automatic issue(input logic [KW-1:0] k, input logic h, input logic [3:0] a);
    bus.lookup_valid = 1'b1;
    bus.lookup_key   = k;
    sb.push_back('{hit: h, addr: a, due: cyc + 2});
  endtask

  task automatic issue_model(input logic [KW-1:0] k);
    logic       h;
    logic [3:0] a;
    h = 1'b0;
    a = '0;
    for (int i = NE-1; i >= 0; i--)
      if (ref_valid[i] && (((k ^ ref_value[i]) & ref_mask[i]) == '0)) begin
        h = 1'b1;
        a = 4'(i);
      end
    issue(k, h, a);
  endtask

  // Handshake now, lookup probes every cycle while busy, count wr_ready-low cycles.
  task automatic do_write(input logic [3:0] a, input logic [KW-1:0] v, input logic [KW-1:0] m,
                          input logic inv, input logic [KW-1:0] pa, input logic [KW-1:0] pb,
                          input int exp_busy);
    int busy;
    bit done;
    check("wr_ready_before_req", 32'(bus.wr_ready), 32'd1);
    bus.wr_valid      = 1'b1;
    bus.wr_invalidate = inv;
    bus.wr_addr       = a;
    bus.wr_value      = v;
    bus.wr_mask       = m;
    issue_model(pa);          // same-cycle lookup sees pre-write state
    ref_valid[a] = 1'b0;
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      bus.wr_valid = 1'b0;
      if (bus.wr_ready) done = 1'b1;
      else begin
        busy++;
        issue_model((i % 2) ? pb : pa);
      end
    end
    check("write_completed", 32'(done), 32'd1);
    check("wr_ready_low_cycles", 32'(busy), 32'(exp_busy));
    if (!inv) begin
      ref_valid[a] = 1'b1;
      ref_value[a] = v;
      ref_mask[a]  = m;
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_latency", 32'(cyc), 32'(e.due));
        check("result_hit", 32'(bus.result_hit), 32'(e.hit));
        check("result_addr", 32'(bus.result_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    vecs[0] = '{key: 10'h2A0, hit: 1'b1, addr: 4'd5};
    vecs[1] = '{key: 10'h2AA, hit: 1'b1, addr: 4'd5};
    vecs[2] = '{key: 10'h2BF, hit: 1'b1, addr: 4'd5};
    vecs[3] = '{key: 10'h2C0, hit: 1'b0, addr: 4'd0};
    vecs[4] = '{key: 10'h29F, hit: 1'b0, addr: 4'd0};
    vecs[5] = '{key: 10'h000, hit: 1'b0, addr: 4'd0};
    vecs[6] = '{key: 10'h2AB, hit: 1'b1, addr: 4'd3};

    for (int i = 0; i < NE; i++) begin
      ref_valid[i] = 1'b0;
      ref_value[i] = '0;
      ref_mask[i]  = '0;
    end

    bus.wr_valid      = 1'b0;
    bus.wr_invalidate = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_value      = '0;
    bus.wr_mask       = '0;
    bus.lookup_valid  = 1'b0;
    bus.lookup_key    = '0;

    // Reset and first lookup.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("wr_ready_after_reset", 32'(bus.wr_ready), 32'd1);
    check("result_valid_after_reset", 32'(bus.result_valid), 32'd0);
    check("result_addr_after_reset", 32'(bus.result_addr), 32'd0);
    tick();
    check("wr_ready_cycle_after_reset", 32'(bus.wr_ready), 32'd1);
    issue(10'h000, 1'b0, 4'd0);
    repeat (4) tick();

    // Exact-match entry 3.
    do_write(4'd3, 10'h2AB, 10'h3FF, 1'b0, 10'h2AB, 10'h2AA, 33);
    issue(10'h2AB, 1'b1, 4'd3);
    tick();
    issue(10'h2AA, 1'b0, 4'd0);
    tick();
    repeat (3) tick();

    // Prefix entry 5 overlapping entry 3.
    do_write(4'd5, 10'h2A0, 10'h3E0, 1'b0, 10'h2A0, 10'h2AB, 33);
    for (int k = 10'h2A0; k <= 10'h2BF; k++) begin
      issue(10'(k), 1'b1, (k == 10'h2AB) ? 4'd3 : 4'd5);
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].key, vecs[i].hit, vecs[i].addr);
      tick();
    end
    repeat (4) tick();
    // No lookups in flight: strobe low, hit/addr hold the last result (2AB).
    check("idle_result_valid", 32'(bus.result_valid), 32'd0);
    check("hold_result_hit", 32'(bus.result_hit), 32'd1);
    check("hold_result_addr", 32'(bus.result_addr), 32'd3);

    // Rewrite entry 3 under continuous lookups.
    do_write(4'd3, 10'h001, 10'h3FF, 1'b0, 10'h2AB, 10'h001, 33);
    issue(10'h001, 1'b1, 4'd3);
    tick();
    issue(10'h2AB, 1'b1, 4'd5);
    tick();
    repeat (3) tick();

    // Invalidate entry 5.
    do_write(4'd5, 10'h000, 10'h000, 1'b1, 10'h2A0, 10'h2A0, 0);
    check("wr_ready_after_invalidate", 32'(bus.wr_ready), 32'd1);
    issue(10'h2A0, 1'b0, 4'd0);
    tick();
    issue(10'h2A0, 1'b0, 4'd0);
    tick();
    repeat (4) tick();

    // Reset during SHIFT of entry 0, with a lookup in flight.
    bus.wr_valid      = 1'b1;
    bus.wr_invalidate = 1'b0;
    bus.wr_addr       = 4'd0;
    bus.wr_value      = 10'h000;
    bus.wr_mask       = 10'h000;
    tick();
    bus.wr_valid = 1'b0;
    check("wr_ready_low_in_shift", 32'(bus.wr_ready), 32'd0);
    repeat (8) tick();
    bus.lookup_valid = 1'b1;  // flushed by reset: no scoreboard entry
    bus.lookup_key   = 10'h000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NE; i++) ref_valid[i] = 1'b0;
    check("wr_ready_after_mid_reset", 32'(bus.wr_ready), 32'd1);
    tick();
    for (int k = 0; k < 1024; k++) begin
      issue(10'(k), 1'b0, 4'd0);
      tick();
    end
    repeat (4) tick();

    // Full write of a match-all entry 0.
    do_write(4'd0, 10'h000, 10'h000, 1'b0, 10'h155, 10'h2AA, 33);
    for (int k = 0; k < 1024; k++) begin
      issue(10'(k), 1'b1, 4'd0);
      tick();
    end
    repeat (5) tick();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/upb_tcam.md
Name: upb_tcam

Overview:
- Multi-entry SRL-style ternary CAM for the OpenFlow lookup path.
- Generalises the single SRL-based TCAM entry to ENTRIES entries and adds:
  - a value/mask write controller that serialises LUT contents into the SRLs;
  - per-entry valid bits;
  - a pipelined lookup with lowest-index priority encoding.
- Sits between header parser key generation and the action/flow table RAM; result_addr indexes that RAM.

Parameters:
- SRL_SIZE, 32, SRL depth; power of two, 16 or 32. Chunk width CW = log2(SRL_SIZE).
- TCAM_WIDTH, 2, chunks per entry; KEY_WIDTH = CW*TCAM_WIDTH (10 at defaults).
- ENTRIES, 16, number of entries, 2..256; AW = max(1, clog2(ENTRIES)).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- wr_valid  in  1  write/invalidate request.
- wr_ready  out  1  controller idle, request accepted when wr_valid&&wr_ready.
- wr_invalidate  in  1  1 = invalidate wr_addr only; value/mask ignored.
- wr_addr  in  AW  target entry.
- wr_value  in  KEY_WIDTH  match value.
- wr_mask  in  KEY_WIDTH  care mask, 1 = bit compared, 0 = don't care.
- lookup_valid  in  1  key present this cycle.
- lookup_key  in  KEY_WIDTH  search key.
- result_valid  out  1  result strobe.
- result_hit  out  1  at least one valid entry matched.
- result_addr  out  AW  lowest matching index; 0 when no hit.

Behaviour:
- Reset: synchronous, CLK edge with RST=1. Clears all valid bits, FSM to IDLE, wr_ready=1, result_valid=0, result_hit=0, result_addr=0, pipeline valids=0. SRL contents are not reset; cleared valid bits mask them.
- Entry storage: per entry, TCAM_WIDTH shift registers of SRL_SIZE bits. Chunk c covers key bits [c*CW +: CW]. Chunk c matches key k iff bit k_c of its SRL is 1. An entry matches iff every chunk matches and the entry is valid.
- LUT generation: bit j of chunk c = ((j ^ value_c) & mask_c) == 0.
- FSM states:
  - IDLE: wr_ready=1. Handshake at cycle T latches addr/value/mask and clears valid[wr_addr] effective T+1.
    - wr_invalidate=1: stay IDLE; done.
    - Otherwise go to SHIFT with counter = SRL_SIZE-1.
  - SHIFT: wr_ready=0. Each cycle, all TCAM_WIDTH SRLs of the target entry shift in LUT bit [counter] in parallel, MSB first, so bit j lands at SRL position j. The counter decrements each cycle. Other entries do not shift.
    - At counter 0, shift the last bit, then go to DONE.
  - DONE: one cycle; set valid[addr], wr_ready=1 next cycle, return to IDLE.
- Write timing: handshake T; shifting occupies T+1..T+SRL_SIZE; DONE at T+SRL_SIZE+1; entry matchable by lookups issued at T+SRL_SIZE+2 and later. wr_ready is low for T+1..T+SRL_SIZE+1.
- Lookup pipeline: fully pipelined, one key per cycle, latency 2.
  - Stage 1 (T+1): register the match vector using SRL contents and valid bits as of cycle T.
  - Stage 2 (T+2): priority encoder drives result_valid/hit/addr.
  - lookup_valid=0 gives result_valid=0 two cycles later; hit/addr hold their last values.
- Simultaneous lookup and write handshake at T: the lookup sees the pre-write state.
- Entry under rewrite is never matched from T+1 until valid is set, so no partial LUT is ever visible.
- Rewriting a valid entry: invalid during the rewrite, then valid with the new contents.
- wr_addr >= ENTRIES: request accepted, no state change, no SHIFT.
- RST mid-SHIFT: aborts, FSM to IDLE, target entry left invalid.
- RST with lookups in flight: flushes them; no result_valid for those lookups.

Optional Feature:
- Macro UPB_TCAM_MATCH_VEC_EN.
- Defined: adds output port result_match [ENTRIES-1:0], the stage-2 registered full match vector (valid-masked), aligned with result_valid and reset to 0. Used by the multi-table statistics path.
- Undefined: port and register are absent. Behaviour of all other ports is identical.

Test Plan:
- Reset then lookup 10'h000: result_valid at +2, result_hit=0, result_addr=0. Check wr_ready=1 in the cycle after reset.
- Write entry 3, value 10'h2AB, mask 10'h3FF:
  - wr_ready low exactly 33 cycles;
  - lookup 10'h2AB gives hit=1, addr=3;
  - lookup 10'h2AA gives hit=0.
- Write entry 5, value 10'h2A0, mask 10'h3E0:
  - keys 10'h2A0..10'h2BF hit; addr=3 for 10'h2AB (priority), addr=5 otherwise;
  - 10'h2C0 misses.
- Lookups each cycle while entry 3 is rewritten to value 10'h001 (mask 10'h3FF): 10'h2AB gives addr=5 from handshake+1 onward. After DONE, 10'h001 gives addr=3.
- Invalidate entry 5 (wr_invalidate=1): wr_ready stays 1; lookup 10'h2A0 two cycles later gives hit=0.
- Assert RST at cycle 10 of a write to entry 0, value 10'h000, mask 10'h000; exhaustive sweep of 1024 keys afterwards gives no hits. Then write it fully: all 1024 keys give hit=1, addr=0.
